// File: rtl/multi_pulse_generator.sv
// Multi-channel pulse generator driven by one shared period counter.
// Optional counted bursts are built when PULSE_GEN_BURST_EN is defined.
module multi_pulse_generator #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 11,
  parameter int BURST_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CNT_W-1:0]          divide_by_n,
  input  logic [CHANNELS*CNT_W-1:0] rise_pos,
  input  logic [CHANNELS*CNT_W-1:0] fall_pos,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS-1:0]       polarity,
  input  logic                      start,
  input  logic [BURST_W-1:0]        burst_len,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic                      tick_comb,
  output logic                      tick_sync,
  output logic                      busy,
  output logic                      done
);

`ifdef PULSE_GEN_BURST_EN
  typedef enum logic [1:0] {IDLE, CONT, BURST} state_t;
`else
  typedef enum logic [0:0] {IDLE, CONT} state_t;
`endif

  state_t                    state;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          p_sh;
  logic [CNT_W-1:0]          last_cnt;
  logic [CHANNELS*CNT_W-1:0] rise_sh;
  logic [CHANNELS*CNT_W-1:0] fall_sh;
  logic [CHANNELS-1:0]       active;
  logic                      run;
  logic                      wrap;
  logic                      load;
  logic                      start_ok;
  logic                      last_burst;

  assign run  = (state != IDLE);
  assign busy = run;

  // P of 0 and 1 both mean a single-cycle period
  assign last_cnt  = (p_sh == '0) ? '0 : p_sh - CNT_W'(1);
  assign tick_comb = run && (count == last_cnt);
  assign wrap      = tick_comb;

`ifdef PULSE_GEN_BURST_EN
  logic [BURST_W-1:0] bcnt;
  logic [BURST_W-1:0] bl_sh;

  assign start_ok   = start && !en && (burst_len != '0);
  assign last_burst = (bcnt == bl_sh - BURST_W'(1));
`else
  logic unused_burst;

  assign unused_burst = ^{start, burst_len};
  assign start_ok     = 1'b0;
  assign last_burst   = 1'b0;
  assign done         = 1'b0;
`endif

  // Shadow reload happens on entry and on every wrap that keeps running
  always_comb begin
    load = 1'b0;
    unique case (state)
      IDLE:    load = en || start_ok;
      CONT:    load = wrap && en;
`ifdef PULSE_GEN_BURST_EN
      BURST:   load = wrap && (!last_burst || en);
`endif
      default: load = 1'b0;
    endcase
  end

  // Per-channel window decode against the shadowed positions
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] r;
    logic [CNT_W-1:0] f;

    assign r = rise_sh[i*CNT_W +: CNT_W];
    assign f = fall_sh[i*CNT_W +: CNT_W];
    assign active[i] = (r < f) ? (count >= r && count < f) :
                       (r > f) ? (count >= r || count < f) :
                       1'b0;
  end

  // Shadow registers for period and channel positions
  always_ff @(posedge clk) begin
    if (rst) begin
      p_sh    <= '0;
      rise_sh <= '0;
      fall_sh <= '0;
    end else if (load) begin
      p_sh    <= divide_by_n;
      rise_sh <= rise_pos;
      fall_sh <= fall_pos;
    end
  end

  // Mode FSM and shared period counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
`ifdef PULSE_GEN_BURST_EN
      bcnt  <= '0;
      bl_sh <= '0;
      done  <= 1'b0;
`endif
    end else begin
`ifdef PULSE_GEN_BURST_EN
      done <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          count <= '0;
          if (en) begin
            state <= CONT;
          end
`ifdef PULSE_GEN_BURST_EN
          else if (start_ok) begin
            state <= BURST;
            bcnt  <= '0;
            bl_sh <= burst_len;
          end
`endif
        end
        CONT: begin
          if (wrap) begin
            count <= '0;
            if (!en) state <= IDLE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
`ifdef PULSE_GEN_BURST_EN
        BURST: begin
          if (wrap) begin
            count <= '0;
            if (last_burst) begin
              done  <= 1'b1;
              bcnt  <= '0;
              state <= en ? CONT : IDLE;
            end else begin
              bcnt <= bcnt + BURST_W'(1);
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Registered outputs, one cycle behind the counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_out <= '0;
      tick_sync <= 1'b0;
    end else begin
      pulse_out <= ({CHANNELS{run}} & ch_en & active) ^ polarity;
      tick_sync <= tick_comb;
    end
  end

endmodule
